// File: rtl/asd_pkg.sv
// Shared state type and constant helpers for the automaton string driver.
package asd_pkg;

    localparam int unsigned MAX_LEN_LIMIT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StShift,
        StCheck,
        StDone,
        StFail
    } asd_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shortlex_counter.sv
// Shortlex enumerator: len/val step through every binary string, shortest first,
// values in increasing order within one length.
module shortlex_counter
    import asd_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [LEN_W-1:0]   len,
    output logic [MAX_LEN-1:0] val,
    output logic               last
);

    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] val_q;
    logic [MAX_LEN-1:0] val_max;
    logic               at_max;

    // All-ones pattern of the current length: the last value before the length grows.
    always_comb begin
        val_max = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            val_max[i] = (i < 32'(len_q));
        end
    end

    assign at_max = (val_q == val_max);
    assign last   = at_max && (len_q == LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            len_q <= '0;
            val_q <= '0;
        end else if (advance && !last) begin
            if (at_max) begin
                len_q <= len_q + LEN_W'(1);
                val_q <= '0;
            end else begin
                val_q <= val_q + MAX_LEN'(1);
            end
        end
    end

    assign len = len_q;
    assign val = val_q;

endmodule

// File: rtl/automaton_string_driver.sv
// Drives every binary string up to MAX_LEN into two automata and stops on the first
// accept-output disagreement, latching the counterexample.
module automaton_string_driver
    import asd_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               dut_reset,
    output logic               dut_in,
    input  logic               acc1,
    input  logic               acc2,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [LEN_W-1:0]   cex_len,
    output logic [MAX_LEN-1:0] cex_bits,
    output logic [CNT_W-1:0]   strings_tested
);

    asd_state_e state_q, state_d;

    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] val;
    logic               last;
    logic               clear;
    logic               advance;

    logic               dut_reset_q, dut_in_q, busy_q;
    logic               dut_in_d;
    logic               done_q, done_d;
    logic               mismatch_q, mismatch_d;
    logic [LEN_W-1:0]   cex_len_q, cex_len_d;
    logic [MAX_LEN-1:0] cex_bits_q, cex_bits_d;
    logic [CNT_W-1:0]   tested_q, tested_d;
    logic [LEN_W-1:0]   sym_sel;

    shortlex_counter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .len     (len),
        .val     (val),
        .last    (last)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clear      = 1'b0;
        advance    = 1'b0;
        done_d     = done_q;
        mismatch_d = mismatch_q;
        cex_len_d  = cex_len_q;
        cex_bits_d = cex_bits_q;
        tested_d   = tested_q;

        case (state_q)
            StIdle, StDone, StFail: begin
                if (start) begin
                    clear      = 1'b1;
                    done_d     = 1'b0;
                    mismatch_d = 1'b0;
                    cex_len_d  = '0;
                    cex_bits_d = '0;
                    tested_d   = '0;
                    state_d    = StRst;
                end
            end
            StRst: begin
                idx_d   = len;
                state_d = (len == '0) ? StCheck : StShift;
            end
            StShift: begin
                idx_d = idx_q - LEN_W'(1);
                if (idx_q == LEN_W'(1)) state_d = StCheck;
            end
            StCheck: begin
                if (acc1 != acc2) begin
                    mismatch_d = 1'b1;
                    cex_len_d  = len;
                    cex_bits_d = val;
                    state_d    = StFail;
                end else begin
                    tested_d = tested_q + CNT_W'(1);
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        advance = 1'b1;
                        state_d = StRst;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so select the symbol for the cycle being entered (MSB first).
        sym_sel  = idx_d - LEN_W'(1);
        dut_in_d = (state_d == StShift) && |(val & (MAX_LEN'(1) << sym_sel));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dut_reset_q <= 1'b0;
            dut_in_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            cex_len_q   <= '0;
            cex_bits_q  <= '0;
            tested_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dut_reset_q <= (state_d == StRst);
            dut_in_q    <= dut_in_d;
            busy_q      <= (state_d == StRst) || (state_d == StShift) || (state_d == StCheck);
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            cex_len_q   <= cex_len_d;
            cex_bits_q  <= cex_bits_d;
            tested_q    <= tested_d;
        end
    end

    assign dut_reset      = dut_reset_q;
    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch       = mismatch_q;
    assign cex_len        = cex_len_q;
    assign cex_bits       = cex_bits_q;
    assign strings_tested = tested_q;

endmodule

// File: tb/tb_automaton_string_driver.sv
// Bench for automaton_string_driver: MAX_LEN=2 trace instance and MAX_LEN=8 checker instance
// driving small mod-3 automaton models.
module tb_automaton_string_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start2, dut_reset2, dut_in2, acc1_2, acc2_2, busy2, done2, mismatch2;
    logic [1:0]  cex_len2, cex_bits2;
    logic [19:0] tested2;

    logic        start8, dut_reset8, dut_in8, acc1_8, acc2_8, busy8, done8, mismatch8;
    logic [3:0]  cex_len8;
    logic [7:0]  cex_bits8;
    logic [19:0] tested8;

    automaton_string_driver #(
        .MAX_LEN (2),
        .LEN_W   (2),
        .CNT_W   (20)
    ) dut2 (
        .clk            (clk),
        .reset          (reset),
        .start          (start2),
        .dut_reset      (dut_reset2),
        .dut_in         (dut_in2),
        .acc1           (acc1_2),
        .acc2           (acc2_2),
        .busy           (busy2),
        .done           (done2),
        .mismatch       (mismatch2),
        .cex_len        (cex_len2),
        .cex_bits       (cex_bits2),
        .strings_tested (tested2)
    );

    automaton_string_driver #(
        .MAX_LEN (8),
        .LEN_W   (4),
        .CNT_W   (20)
    ) dut8 (
        .clk            (clk),
        .reset          (reset),
        .start          (start8),
        .dut_reset      (dut_reset8),
        .dut_in         (dut_in8),
        .acc1           (acc1_8),
        .acc2           (acc2_8),
        .busy           (busy8),
        .done           (done8),
        .mismatch       (mismatch8),
        .cex_len        (cex_len8),
        .cex_bits       (cex_bits8),
        .strings_tested (tested8)
    );

    // Automaton models: accept when the count of ones is a multiple of three.
    logic [1:0] m2_q;
    logic [1:0] a_q;
    logic [2:0] b_q;
    logic [1:0] hlen_q, hist_q;
    logic [1:0] mode;

    always_ff @(posedge clk) begin
        if (reset || dut_reset2) m2_q <= 2'd0;
        else if (dut_in2) m2_q <= (m2_q == 2'd2) ? 2'd0 : m2_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset || dut_reset8) begin
            a_q    <= 2'd0;
            b_q    <= 3'b001;
            hlen_q <= 2'd0;
            hist_q <= 2'd0;
        end else begin
            if (dut_in8) begin
                a_q <= (a_q == 2'd2) ? 2'd0 : a_q + 2'd1;
                b_q <= {b_q[1:0], b_q[2]};
            end
            hist_q <= {hist_q[0], dut_in8};
            hlen_q <= (hlen_q == 2'd3) ? 2'd3 : hlen_q + 2'd1;
        end
    end

    assign acc1_2 = (m2_q == 2'd0);
    assign acc2_2 = (m2_q == 2'd0);
    assign acc1_8 = (a_q == 2'd0);
    // mode 1 flips acceptance of "11" only; mode 2 flips acceptance of the empty string.
    assign acc2_8 = b_q[0] ^ ((mode == 2'd1) && (hlen_q == 2'd2) && (hist_q == 2'b11))
                           ^ ((mode == 2'd2) && (hlen_q == 2'd0));

    typedef struct {
        logic        done;
        logic        mm;
        logic [3:0]  len;
        logic [7:0]  bits;
        logic [19:0] tested;
        int          cycles;
    } res_t;

    res_t       res_q[$];
    logic [1:0] trace_q[$];
    // {dut_reset, dut_in} per cycle for strings e,0,1,00,01,10,11.
    logic [1:0] gold [24] = '{2'b10, 2'b00,
                              2'b10, 2'b00, 2'b00,
                              2'b10, 2'b01, 2'b00,
                              2'b10, 2'b00, 2'b00, 2'b00,
                              2'b10, 2'b00, 2'b01, 2'b00,
                              2'b10, 2'b01, 2'b00, 2'b00,
                              2'b10, 2'b01, 2'b01, 2'b00};

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_res(input logic d, input logic mm, input logic [3:0] len,
                            input logic [7:0] bits, input logic [19:0] tested, input int cycles);
        res_t r;
        r.done = d; r.mm = mm; r.len = len; r.bits = bits; r.tested = tested; r.cycles = cycles;
        res_q.push_back(r);
    endtask

    task automatic pop_res(input string tag, output res_t r, output bit ok);
        check({tag, "_sb_size"}, 64'(res_q.size()), 64'(1));
        ok = (res_q.size() != 0);
        if (ok) r = res_q.pop_front();
    endtask

    task automatic run2(input string tag, input int pulse_at);
        res_t r;
        bit   ok;
        trace_q.delete();
        for (int i = 0; i < 24; i++) trace_q.push_back(gold[i]);
        push_res(1'b1, 1'b0, 4'd0, 8'd0, 20'd7, 24);
        start2 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start2 = (c == pulse_at);
            if (c == 1) begin
                check({tag, "_done_clr"}, 64'(done2), 64'(0));
                check({tag, "_cnt_clr"}, 64'(tested2), 64'(0));
            end
            check({tag, "_trace"}, 64'({busy2, dut_reset2, dut_in2}),
                  64'({1'b1, trace_q.pop_front()}));
        end
        start2 = 1'b0;
        tick();
        pop_res(tag, r, ok);
        if (ok) begin
            check({tag, "_busy"}, 64'(busy2), 64'(0));
            check({tag, "_done"}, 64'(done2), 64'(r.done));
            check({tag, "_mismatch"}, 64'(mismatch2), 64'(r.mm));
            check({tag, "_cex"}, 64'({cex_len2, cex_bits2}), 64'({r.len[1:0], r.bits[1:0]}));
            check({tag, "_tested"}, 64'(tested2), 64'(r.tested));
        end
    endtask

    task automatic run8(input string tag, input bit prefix);
        res_t r;
        bit   ok;
        int   c;
        int   busy_cycles;
        trace_q.delete();
        if (prefix) for (int i = 0; i < 24; i++) trace_q.push_back(gold[i]);
        start8      = 1'b1;
        c           = 0;
        busy_cycles = 0;
        while (c < 6000) begin
            tick();
            start8 = 1'b0;
            c++;
            if (prefix && c <= 24) begin
                check({tag, "_trace"}, 64'({dut_reset8, dut_in8}), 64'(trace_q.pop_front()));
            end
            if (!busy8) break;
            busy_cycles++;
        end
        check({tag, "_finished"}, 64'(busy8), 64'(0));
        pop_res(tag, r, ok);
        if (ok) begin
            check({tag, "_cycles"}, 64'(busy_cycles), 64'(r.cycles));
            check({tag, "_done"}, 64'(done8), 64'(r.done));
            check({tag, "_mismatch"}, 64'(mismatch8), 64'(r.mm));
            check({tag, "_cex_len"}, 64'(cex_len8), 64'(r.len));
            check({tag, "_cex_bits"}, 64'(cex_bits8), 64'(r.bits));
            check({tag, "_tested"}, 64'(tested8), 64'(r.tested));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int c;
        reset  = 1'b1;
        start2 = 1'b0;
        start8 = 1'b0;
        mode   = 2'd0;
        repeat (3) tick();
        check("reset8_ctrl", 64'({busy8, done8, mismatch8, dut_reset8, dut_in8}), 64'(0));
        check("reset8_data", 64'({cex_len8, cex_bits8, tested8}), 64'(0));
        check("reset2_all", 64'({busy2, done2, mismatch2, dut_reset2, dut_in2, cex_len2,
                                 cex_bits2, tested2}), 64'(0));
        reset = 1'b0;
        tick();
        check("idle8_busy", 64'(busy8), 64'(0));

        // Golden trace with a stray start mid-run, then a restart from DONE.
        run2("run2", 10);
        run2("restart2", 0);

        // Equivalent automata: 2^9-1 strings, sum of 2^L*(L+2) for L=0..8 = 4608 cycles.
        mode = 2'd0;
        push_res(1'b1, 1'b0, 4'd0, 8'd0, 20'd511, 4608);
        run8("full8", 1'b1);

        // Disagree only on "11": e,0,1,00,01,10 agree (20 cycles) then 4 cycles for "11".
        mode = 2'd1;
        push_res(1'b0, 1'b1, 4'd2, 8'b0000_0011, 20'd6, 24);
        run8("cex11", 1'b0);

        // Disagree on the empty string: RST then CHECK.
        mode = 2'd2;
        push_res(1'b0, 1'b1, 4'd0, 8'd0, 20'd0, 2);
        run8("cex_empty", 1'b0);

        // Reset during the first length-5 string (the 32nd string, after 31 agreed).
        mode   = 2'd0;
        start8 = 1'b1;
        pulses = 0;
        c      = 0;
        while (c < 2000 && pulses < 32) begin
            tick();
            start8 = 1'b0;
            c++;
            if (dut_reset8) pulses++;
        end
        check("len5_reached", 64'(pulses), 64'(32));
        check("len5_tested", 64'(tested8), 64'(31));
        tick();
        tick();
        check("len5_in_shift", 64'({busy8, dut_reset8}), 64'(2'b10));
        reset = 1'b1;
        tick();
        check("midreset_ctrl", 64'({busy8, done8, mismatch8, dut_reset8, dut_in8}), 64'(0));
        check("midreset_data", 64'({cex_len8, cex_bits8, tested8}), 64'(0));
        reset = 1'b0;
        tick();
        check("midreset_idle", 64'(busy8), 64'(0));
        push_res(1'b1, 1'b0, 4'd0, 8'd0, 20'd511, 4608);
        run8("rerun8", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
